// File: rtl/vedic_pkg.sv
// Shared types and constants for the sequential Vedic 8x8 multiplier.
// The NEG state exists only when VEDIC_SEQ_SIGNED_EN is defined.
package vedic_pkg;

    localparam int unsigned OPW = 8;
    localparam int unsigned PRW = 16;

`ifdef VEDIC_SEQ_SIGNED_EN
    typedef enum logic [1:0] {StIdle, StCalc, StNeg, StDone} state_e;
`else
    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;
`endif

    localparam logic [1:0] STEP_LL = 2'd0;
    localparam logic [1:0] STEP_HL = 2'd1;
    localparam logic [1:0] STEP_LH = 2'd2;
    localparam logic [1:0] STEP_HH = 2'd3;

    // Left shift applied to the 4x4 partial product, indexed by step.
    localparam int unsigned STEP_SHIFT [4] = '{0, 4, 4, 8};

    // Vertical-and-crosswise 2x2 product built from gates.
    function automatic logic [3:0] mul2x2(input logic [1:0] x, input logic [1:0] y);
        logic c1;
        logic [3:0] p;
        p[0] = x[0] & y[0];
        p[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
        c1   = (x[1] & y[0]) & (x[0] & y[1]);
        p[2] = (x[1] & y[1]) ^ c1;
        p[3] = (x[1] & y[1]) & c1;
        return p;
    endfunction

endpackage

// File: rtl/vedic_4x4.sv
// Combinational 4x4 unsigned Vedic multiplier made of four 2x2 blocks.
module vedic_4x4
    import vedic_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    logic [3:0] q_ll, q_hl, q_lh, q_hh;

    always_comb begin
        q_ll = mul2x2(a[1:0], b[1:0]);
        q_hl = mul2x2(a[3:2], b[1:0]);
        q_lh = mul2x2(a[1:0], b[3:2]);
        q_hh = mul2x2(a[3:2], b[3:2]);
        p    = {4'b0000, q_ll} + {2'b00, q_hl, 2'b00} + {2'b00, q_lh, 2'b00}
             + {q_hh, 4'b0000};
    end

endmodule

// File: rtl/vedic_8x8_seq.sv
// Sequential 8x8 multiplier: one shared vedic_4x4 core, four partial products
// accumulated over four cycles. VEDIC_SEQ_SIGNED_EN adds is_signed and a NEG cycle.
module vedic_8x8_seq
    import vedic_pkg::*;
#(
    parameter int unsigned ZERO_BYPASS   = 1,
    parameter int unsigned HOLD_OPERANDS = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
`ifdef VEDIC_SEQ_SIGNED_EN
    input  logic           is_signed,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [PRW-1:0] product
);

    state_e         state_q, state_d;
    logic [1:0]     step_q, step_d;
    logic [PRW-1:0] acc_q, acc_d, acc_sum;
    logic [PRW-1:0] product_q, product_d;
    logic [OPW-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]     core_a, core_b;
    logic [7:0]     core_p;
`ifdef VEDIC_SEQ_SIGNED_EN
    logic           neg_q, neg_d;
`endif

    vedic_4x4 u_core (
        .a (core_a),
        .b (core_b),
        .p (core_p)
    );

    always_comb begin
        core_a = a_q[3:0];
        core_b = b_q[3:0];
        unique case (step_q)
            STEP_LL: begin core_a = a_q[3:0]; core_b = b_q[3:0]; end
            STEP_HL: begin core_a = a_q[7:4]; core_b = b_q[3:0]; end
            STEP_LH: begin core_a = a_q[3:0]; core_b = b_q[7:4]; end
            STEP_HH: begin core_a = a_q[7:4]; core_b = b_q[7:4]; end
            default: ;
        endcase
        acc_sum = acc_q + (PRW'(core_p) << STEP_SHIFT[step_q]);
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        acc_d     = acc_q;
        product_d = product_q;
        a_d       = a_q;
        b_d       = b_q;
`ifdef VEDIC_SEQ_SIGNED_EN
        neg_d     = neg_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
`ifdef VEDIC_SEQ_SIGNED_EN
                    // Run the unsigned datapath on magnitudes; 0x80 stays 0x80.
                    a_d   = (is_signed && a[OPW-1]) ? -a : a;
                    b_d   = (is_signed && b[OPW-1]) ? -b : b;
                    neg_d = is_signed && (a[OPW-1] ^ b[OPW-1]);
`else
                    a_d = a;
                    b_d = b;
`endif
                    step_d  = STEP_LL;
                    acc_d   = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if ((ZERO_BYPASS != 0) && (step_q == STEP_LL) && (a_q == '0 || b_q == '0)) begin
                    acc_d     = '0;
                    product_d = '0;
                    step_d    = STEP_LL;
                    state_d   = StDone;
                end else begin
                    acc_d  = acc_sum;
                    step_d = step_q + 2'd1;
                    if (step_q == STEP_HH) begin
`ifdef VEDIC_SEQ_SIGNED_EN
                        if (neg_q) begin
                            state_d = StNeg;
                        end else begin
                            product_d = acc_sum;
                            state_d   = StDone;
                        end
`else
                        product_d = acc_sum;
                        state_d   = StDone;
`endif
                    end
                end
            end
`ifdef VEDIC_SEQ_SIGNED_EN
            StNeg: begin
                acc_d     = -acc_q;
                product_d = -acc_q;
                state_d   = StDone;
            end
`endif
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                    if (HOLD_OPERANDS == 0) begin
                        a_d = '0;
                        b_d = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            step_q    <= STEP_LL;
            acc_q     <= '0;
            product_q <= '0;
            a_q       <= '0;
            b_q       <= '0;
`ifdef VEDIC_SEQ_SIGNED_EN
            neg_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            a_q       <= a_d;
            b_q       <= b_d;
`ifdef VEDIC_SEQ_SIGNED_EN
            neg_q     <= neg_d;
`endif
        end
    end

    // in_ready is gated by rst so it reads 0 while reset is held.
    assign in_ready  = (state_q == StIdle) && !rst;
    assign out_valid = (state_q == StDone);
    assign product   = product_q;

endmodule

// File: tb/tb_vedic_8x8_seq.sv
// Self-checking bench for vedic_8x8_seq with a product scoreboard queue.
module tb_vedic_8x8_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  a, b;
    logic [15:0] product;
    logic        in_valid2, in_ready2, out_valid2, out_ready2;
    logic [7:0]  a2, b2;
    logic [15:0] product2;
`ifdef VEDIC_SEQ_SIGNED_EN
    logic        is_signed = 1'b0;
    logic        is_signed2 = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    logic [15:0] sb [$];

    always #5 clk = ~clk;

    vedic_8x8_seq u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef VEDIC_SEQ_SIGNED_EN
        .is_signed (is_signed),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    vedic_8x8_seq #(
        .ZERO_BYPASS   (0),
        .HOLD_OPERANDS (0)
    ) u_dut_nb (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .a         (a2),
        .b         (b2),
`ifdef VEDIC_SEQ_SIGNED_EN
        .is_signed (is_signed2),
`endif
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .product   (product2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [7:0] xa, input logic [7:0] xb, input logic [15:0] exp);
        in_valid = 1'b1;
        a        = xa;
        b        = xb;
        sb.push_back(exp);
        tick();
        in_valid = 1'b0;
        a        = 8'h00;
        b        = 8'h00;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic release_output();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 0; a = 0; b = 0; out_ready = 0;
        in_valid2 = 0; a2 = 0; b2 = 0; out_ready2 = 0;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready got=%b want=0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || product !== 16'h0000) begin
            failures++;
            $display("FAIL reset_outputs got valid=%b product=%h want 0/0000", out_valid, product);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_in_ready got=%b want=1", in_ready);
        end
    endtask

    task automatic test_basic();
        int n;
        logic [15:0] exp;
        accept(8'h12, 8'h34, 16'h03A8);
        wait_valid(n);
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL basic_latency got=%0d want=4", n);
        end
        exp = sb.pop_front();
        checks++;
        if (product !== exp) begin
            failures++;
            $display("FAIL basic_product got=%h want=%h", product, exp);
        end
        release_output();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_return_idle got valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_hold();
        int n;
        logic [15:0] exp;
        accept(8'hFF, 8'hFF, 16'hFE01);
        wait_valid(n);
        exp = sb.pop_front();
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL hold_latency got=%0d want=4", n);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || product !== exp || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_stable cycle=%0d got valid=%b product=%h ready=%b want 1/%h/0",
                         i, out_valid, product, in_ready, exp);
            end
            tick();
        end
        release_output();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== exp) begin
            failures++;
            $display("FAIL hold_release got ready=%b valid=%b product=%h want 1/0/%h",
                     in_ready, out_valid, product, exp);
        end
    endtask

    task automatic test_zero_bypass();
        int n;
        logic [15:0] exp;
        accept(8'h00, 8'h5A, 16'h0000);
        wait_valid(n);
        exp = sb.pop_front();
        checks++;
        if (n != 1 || product !== exp) begin
            failures++;
            $display("FAIL bypass_a0 got lat=%0d product=%h want 1/%h", n, product, exp);
        end
        release_output();
        accept(8'h77, 8'h00, 16'h0000);
        wait_valid(n);
        exp = sb.pop_front();
        checks++;
        if (n != 1 || product !== exp) begin
            failures++;
            $display("FAIL bypass_b0 got lat=%0d product=%h want 1/%h", n, product, exp);
        end
        release_output();
        // Second instance has the bypass disabled.
        in_valid2 = 1'b1;
        a2 = 8'h00;
        b2 = 8'h5A;
        tick();
        in_valid2 = 1'b0;
        n = 0;
        while (!out_valid2 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != 4 || product2 !== 16'h0000) begin
            failures++;
            $display("FAIL nobypass got lat=%0d product=%h want 4/0000", n, product2);
        end
        out_ready2 = 1'b1;
        tick();
        out_ready2 = 1'b0;
        checks++;
        if (out_valid2 !== 1'b0 || in_ready2 !== 1'b1) begin
            failures++;
            $display("FAIL nobypass_idle got valid=%b ready=%b want 0/1", out_valid2, in_ready2);
        end
    endtask

    task automatic test_abort();
        int n;
        int seen;
        logic [15:0] exp;
        accept(8'hA5, 8'h3C, 16'h26AC);
        tick();
        tick();
        rst = 1'b1;
        #1;
        sb.delete();
        checks++;
        if (out_valid !== 1'b0 || product !== 16'h0000 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_reset got valid=%b product=%h ready=%b want 0/0000/0",
                     out_valid, product, in_ready);
        end
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL abort_no_valid got pulses=%0d want=0", seen);
        end
        accept(8'h03, 8'h07, 16'h0015);
        wait_valid(n);
        exp = sb.pop_front();
        checks++;
        if (n != 4 || product !== exp) begin
            failures++;
            $display("FAIL abort_next got lat=%0d product=%h want 4/%h", n, product, exp);
        end
        release_output();
    endtask

    task automatic test_back_to_back();
        int pushes = 0;
        int got = 0;
        int cyc = 0;
        logic prev_ready = 1'b0;
        logic [15:0] exp;
        in_valid = 1'b1;
        a = 8'($urandom);
        b = 8'($urandom);
        while (got < 20 && cyc < 2000) begin
            out_ready = 1'($urandom_range(0, 1));
            if (in_ready && (prev_ready || out_valid)) begin
                checks++;
                failures++;
                $display("FAIL b2b_in_ready_pulse got ready=%b prev=%b valid=%b want single pulse",
                         in_ready, prev_ready, out_valid);
            end
            prev_ready = in_ready;
            if (in_ready && in_valid) begin
                sb.push_back({8'h00, a} * {8'h00, b});
                pushes++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_unexpected got product=%h want none", product);
                end else begin
                    exp = sb.pop_front();
                    if (product !== exp) begin
                        failures++;
                        $display("FAIL b2b_product got=%h want=%h", product, exp);
                    end
                end
                got++;
            end
            tick();
            cyc++;
            // Operands change every cycle; only the accept-cycle values matter.
            a = 8'($urandom);
            b = 8'($urandom);
            if (pushes >= 20) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (got != 20 || sb.size() != 0) begin
            failures++;
            $display("FAIL b2b_count got=%0d left=%0d want 20/0", got, sb.size());
        end
    endtask

`ifdef VEDIC_SEQ_SIGNED_EN
    task automatic test_signed();
        int n;
        logic [15:0] exp;
        is_signed = 1'b1;
        accept(8'hFF, 8'h02, 16'hFFFE);
        wait_valid(n);
        exp = sb.pop_front();
        checks++;
        if (n != 5 || product !== exp) begin
            failures++;
            $display("FAIL signed_neg got lat=%0d product=%h want 5/%h", n, product, exp);
        end
        release_output();
        accept(8'h80, 8'h80, 16'h4000);
        wait_valid(n);
        exp = sb.pop_front();
        checks++;
        if (n != 4 || product !== exp) begin
            failures++;
            $display("FAIL signed_min got lat=%0d product=%h want 4/%h", n, product, exp);
        end
        release_output();
        is_signed = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_zero_bypass();
        test_abort();
        test_back_to_back();
`ifdef VEDIC_SEQ_SIGNED_EN
        test_signed();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
